// File: rtl/waves_pkg.sv
// Shared widths, wave-select encodings and small sample helpers for the
// tt_um_waves phase-accumulator waveform generator.
package waves_pkg;

  localparam int ACC_W   = 16;
  localparam int PHASE_W = 8;

  localparam logic [1:0] WAVE_SQUARE = 2'b00;
  localparam logic [1:0] WAVE_SAW    = 2'b01;
  localparam logic [1:0] WAVE_TRI    = 2'b10;
  localparam logic [1:0] WAVE_SINE   = 2'b11;

  // Frequency code 0..63 maps to a step of 1..64 so the generator never stalls.
  function automatic logic [ACC_W-1:0] freq_step(input logic [5:0] f);
    return {{(ACC_W-6){1'b0}}, f} + ACC_W'(1);
  endfunction

  function automatic logic [PHASE_W-1:0] square_sample(input logic [PHASE_W-1:0] p);
    return p[PHASE_W-1] ? 8'hFF : 8'h00;
  endfunction

  // Rising half doubles the phase, falling half mirrors it, giving 0..254 then 255..1.
  function automatic logic [PHASE_W-1:0] tri_sample(input logic [PHASE_W-1:0] p);
    logic [PHASE_W-1:0] t;
    t = {p[PHASE_W-2:0], 1'b0};
    return p[PHASE_W-1] ? ~t : t;
  endfunction

  function automatic logic [5:0] sine_quarter_idx(input logic [PHASE_W-1:0] p);
    return p[6] ? ~p[5:0] : p[5:0];
  endfunction

  function automatic logic [PHASE_W-1:0] sine_sample(input logic [PHASE_W-1:0] p,
                                                     input logic [6:0] mag);
    return p[PHASE_W-1] ? (8'd128 - {1'b0, mag}) : (8'd128 + {1'b0, mag});
  endfunction

endpackage

// File: rtl/sine_lut.sv
// Quarter-wave sine ROM: mag = round(127 * sin(2*pi*idx/256)) for idx 0..63.
module sine_lut (
  input  logic [5:0] idx,
  output logic [6:0] mag
);

  always_comb begin
    mag = 7'd0;
    case (idx)
      6'd0:  mag = 7'd0;
      6'd1:  mag = 7'd3;
      6'd2:  mag = 7'd6;
      6'd3:  mag = 7'd9;
      6'd4:  mag = 7'd12;
      6'd5:  mag = 7'd16;
      6'd6:  mag = 7'd19;
      6'd7:  mag = 7'd22;
      6'd8:  mag = 7'd25;
      6'd9:  mag = 7'd28;
      6'd10: mag = 7'd31;
      6'd11: mag = 7'd34;
      6'd12: mag = 7'd37;
      6'd13: mag = 7'd40;
      6'd14: mag = 7'd43;
      6'd15: mag = 7'd46;
      6'd16: mag = 7'd49;
      6'd17: mag = 7'd51;
      6'd18: mag = 7'd54;
      6'd19: mag = 7'd57;
      6'd20: mag = 7'd60;
      6'd21: mag = 7'd63;
      6'd22: mag = 7'd65;
      6'd23: mag = 7'd68;
      6'd24: mag = 7'd71;
      6'd25: mag = 7'd73;
      6'd26: mag = 7'd76;
      6'd27: mag = 7'd78;
      6'd28: mag = 7'd81;
      6'd29: mag = 7'd83;
      6'd30: mag = 7'd85;
      6'd31: mag = 7'd88;
      6'd32: mag = 7'd90;
      6'd33: mag = 7'd92;
      6'd34: mag = 7'd94;
      6'd35: mag = 7'd96;
      6'd36: mag = 7'd98;
      6'd37: mag = 7'd100;
      6'd38: mag = 7'd102;
      6'd39: mag = 7'd104;
      6'd40: mag = 7'd106;
      6'd41: mag = 7'd107;
      6'd42: mag = 7'd109;
      6'd43: mag = 7'd111;
      6'd44: mag = 7'd112;
      6'd45: mag = 7'd113;
      6'd46: mag = 7'd115;
      6'd47: mag = 7'd116;
      6'd48: mag = 7'd117;
      6'd49: mag = 7'd118;
      6'd50: mag = 7'd120;
      6'd51: mag = 7'd121;
      6'd52: mag = 7'd122;
      6'd53: mag = 7'd122;
      6'd54: mag = 7'd123;
      6'd55: mag = 7'd124;
      6'd56: mag = 7'd125;
      6'd57: mag = 7'd125;
      6'd58: mag = 7'd126;
      6'd59: mag = 7'd126;
      6'd60: mag = 7'd126;
      6'd61: mag = 7'd127;
      6'd62: mag = 7'd127;
      6'd63: mag = 7'd127;
      default: mag = 7'd0;
    endcase
  end

endmodule

// File: rtl/tt_um_waves.sv
// Tiny Tapeout waveform generator: 16-bit phase accumulator feeding a
// square/saw/triangle/sine mux, registered 8-bit sample plus wrap sync pulse.
module tt_um_waves
  import waves_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // rst_n keeps the harness name but is an active-high asynchronous reset.
  logic rst;
  assign rst = rst_n;

  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [PHASE_W-1:0] sample_q, sample_d;
  logic               sync_q, sync_d;

  logic [ACC_W-1:0]   step;
  logic [ACC_W:0]     acc_sum;
  logic [PHASE_W-1:0] phase;
  logic [5:0]         sine_idx;
  logic [6:0]         sine_mag;
  logic [PHASE_W-1:0] wave_sample;
  logic               unused_uio;

  assign step     = freq_step(ui_in[7:2]);
  assign acc_sum  = {1'b0, acc_q} + {1'b0, step};
  assign phase    = acc_q[ACC_W-1:ACC_W-PHASE_W];
  assign sine_idx = sine_quarter_idx(phase);

  sine_lut u_sine_lut (
    .idx (sine_idx),
    .mag (sine_mag)
  );

  // Sample is taken from the phase before this cycle's update.
  always_comb begin
    wave_sample = 8'h00;
    case (ui_in[1:0])
      WAVE_SQUARE: wave_sample = square_sample(phase);
      WAVE_SAW:    wave_sample = phase;
      WAVE_TRI:    wave_sample = tri_sample(phase);
      WAVE_SINE:   wave_sample = sine_sample(phase, sine_mag);
      default:     wave_sample = 8'h00;
    endcase
  end

  // With ena low everything holds, including a sync pulse already in flight.
  always_comb begin
    acc_d    = acc_q;
    sample_d = sample_q;
    sync_d   = sync_q;
    if (ena) begin
      acc_d    = acc_sum[ACC_W-1:0];
      sample_d = wave_sample;
      sync_d   = acc_sum[ACC_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      sample_q <= '0;
      sync_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sample_q <= sample_d;
      sync_q   <= sync_d;
    end
  end

  assign uo_out     = sample_q;
  assign uio_out    = {7'b0000000, sync_q};
  assign uio_oe     = 8'h01;
  assign unused_uio = &{1'b0, uio_in};

endmodule

// File: tb/tb_tt_um_waves.sv
// Directed scoreboard bench for tt_um_waves: expected samples are queued
// against an absolute clock-edge index and checked by an independent monitor.
module tb_tt_um_waves;

  localparam int W = 41;  // {edge index[31:0], uo_out[7:0], sync}

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  int unsigned edge_n;
  int unsigned base;
  int          n_checks;
  int          n_fail;

  tt_um_waves dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    edge_n = 0;
  end

  always @(posedge clk) edge_n = edge_n + 1;

  initial begin
    #600000;
    $display("FAIL timeout: edge_n=%0d expected completion", edge_n);
    n_fail = n_fail + 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: pops every expectation whose edge index has been reached.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    string        t;
    while (exp_q.size() > 0 && exp_q[0][W-1 -: 32] <= edge_n) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, " edge"}, edge_n, e[W-1 -: 32]);
      check({t, " uo_out"}, {24'd0, uo_out}, {24'd0, e[8:1]});
      check({t, " uio_out"}, {24'd0, uio_out}, {31'd0, e[0]});
      check({t, " uio_oe"}, {24'd0, uio_oe}, 32'h01);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_at(input int unsigned k, input logic [7:0] uo, input logic sy,
                           input string tag);
    exp_q.push_back({base + k, uo, sy});
    tag_q.push_back(tag);
  endtask

  task automatic run_to(input int unsigned k);
    while (edge_n < base + k) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Releases reset away from the edge; edge k after this is base+k.
  task automatic start_seg(input logic [7:0] v);
    @(negedge clk);
    ui_in = v;
    ena   = 1'b1;
    rst_n = 1'b0;
    base  = edge_n;
  endtask

  task automatic drain(input string name);
    check({name, " drain"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    base     = 0;
    rst_n    = 1'b1;
    ena      = 1'b1;
    ui_in    = 8'hFF;
    uio_in   = 8'hA5;

    // Reset held with clock running and ena high.
    expect_at(2, 8'h00, 1'b0, "rst_hold_a");
    expect_at(4, 8'h00, 1'b0, "rst_hold_b");
    run_to(5);
    drain("reset");

    // Sawtooth F=63 (step 64), then enable freeze and live wave change.
    start_seg(8'hFD);
    expect_at(1,    8'd0,   1'b0, "saw_k1");
    expect_at(5,    8'd1,   1'b0, "saw_k5");
    expect_at(401,  8'd100, 1'b0, "saw_k401");
    expect_at(1023, 8'd255, 1'b0, "saw_k1023");
    expect_at(1024, 8'd255, 1'b1, "saw_wrap");
    expect_at(1025, 8'd0,   1'b0, "saw_restart");
    expect_at(1026, 8'd0,   1'b0, "saw_k1026");
    expect_at(1030, 8'd1,   1'b0, "saw_k1030");
    expect_at(1031, 8'd1,   1'b0, "ena_off_first");
    expect_at(1080, 8'd1,   1'b0, "ena_off_last");
    expect_at(1083, 8'd2,   1'b0, "ena_resume_p2");
    expect_at(1087, 8'd3,   1'b0, "ena_resume_p3");
    expect_at(2098, 8'd255, 1'b1, "saw_wrap2");
    expect_at(2099, 8'd255, 1'b1, "sync_frozen_a");
    expect_at(2103, 8'd255, 1'b1, "sync_frozen_b");
    expect_at(2104, 8'd0,   1'b0, "sync_release");
    expect_at(2105, 8'd128, 1'b0, "swap_sine_p0");
    expect_at(2108, 8'd131, 1'b0, "swap_sine_p1");
    expect_at(2110, 8'd131, 1'b0, "swap_sine_k2110");
    run_to(1030);
    ena = 1'b0;
    run_to(1080);
    ena = 1'b1;
    run_to(2098);
    ena = 1'b0;
    run_to(2103);
    ena = 1'b1;
    run_to(2104);
    ui_in = 8'hFF;
    run_to(2110);
    drain("saw");

    // Asynchronous reset mid-run, sampled before the next rising edge.
    #2 rst_n = 1'b1;
    #1;
    check("async_rst uo_out", {24'd0, uo_out}, 32'h00);
    check("async_rst uio_out", {24'd0, uio_out}, 32'h00);
    check("async_rst uio_oe", {24'd0, uio_oe}, 32'h01);

    // Square F=63.
    do_reset();
    start_seg(8'hFC);
    expect_at(1,    8'h00, 1'b0, "sq_k1");
    expect_at(512,  8'h00, 1'b0, "sq_k512");
    expect_at(513,  8'hFF, 1'b0, "sq_k513");
    expect_at(1024, 8'hFF, 1'b1, "sq_wrap");
    expect_at(1025, 8'h00, 1'b0, "sq_k1025");
    run_to(1026);
    drain("square");

    // Triangle F=63: p = (k-1)/4.
    do_reset();
    start_seg(8'hFE);
    expect_at(1,    8'd0,   1'b0, "tri_p0");
    expect_at(257,  8'd128, 1'b0, "tri_p64");
    expect_at(509,  8'd254, 1'b0, "tri_p127");
    expect_at(513,  8'd255, 1'b0, "tri_p128");
    expect_at(1021, 8'd1,   1'b0, "tri_p255");
    expect_at(1024, 8'd1,   1'b1, "tri_wrap");
    run_to(1025);
    drain("triangle");

    // Sine F=63.
    do_reset();
    start_seg(8'hFF);
    expect_at(1,    8'd128, 1'b0, "sin_p0");
    expect_at(65,   8'd177, 1'b0, "sin_p16");
    expect_at(129,  8'd218, 1'b0, "sin_p32");
    expect_at(257,  8'd255, 1'b0, "sin_p64");
    expect_at(513,  8'd128, 1'b0, "sin_p128");
    expect_at(769,  8'd1,   1'b0, "sin_p192");
    expect_at(801,  8'd4,   1'b0, "sin_p200");
    expect_at(1021, 8'd128, 1'b0, "sin_p255");
    run_to(1022);
    drain("sine");

    // Low frequency codes: F=1 (step 2) and F=0 (step 1), sawtooth.
    do_reset();
    start_seg(8'h05);
    expect_at(128, 8'd0, 1'b0, "f1_k128");
    expect_at(129, 8'd1, 1'b0, "f1_k129");
    run_to(130);
    drain("f1");

    do_reset();
    start_seg(8'h01);
    expect_at(256, 8'd0, 1'b0, "f0_k256");
    expect_at(257, 8'd1, 1'b0, "f0_k257");
    run_to(258);
    drain("f0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
